// File: rtl/ibex_icache_ram_arbiter_if.sv
// Bus bundle between the icache core, the bank arbiter and the RAM wrapper.
// The arbiter uses the slave view; the core/RAM side uses the master view.
interface ibex_icache_ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    logic              inval_req_i;
    logic              inval_busy_o;
    logic              fill_req_i;
    logic [ADDR_W-1:0] fill_addr_i;
    logic [DATA_W-1:0] fill_wdata_i;
    logic [DATA_W-1:0] fill_wmask_i;
    logic              fill_gnt_o;
    logic              lkp_req_i;
    logic [ADDR_W-1:0] lkp_addr_i;
    logic              lkp_gnt_o;
    logic              lkp_rvalid_o;
    logic [DATA_W-1:0] lkp_rdata_o;
    logic              ram_req_o;
    logic              ram_write_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_wmask_o;
    logic [DATA_W-1:0] ram_rdata_i;

    modport slave (
        input  inval_req_i, fill_req_i, fill_addr_i, fill_wdata_i, fill_wmask_i,
        input  lkp_req_i, lkp_addr_i, ram_rdata_i,
        output inval_busy_o, fill_gnt_o, lkp_gnt_o, lkp_rvalid_o, lkp_rdata_o,
        output ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_wmask_o
    );

    modport master (
        output inval_req_i, fill_req_i, fill_addr_i, fill_wdata_i, fill_wmask_i,
        output lkp_req_i, lkp_addr_i, ram_rdata_i,
        input  inval_busy_o, fill_gnt_o, lkp_gnt_o, lkp_rvalid_o, lkp_rdata_o,
        input  ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_wmask_o
    );
endinterface

// File: rtl/ibex_icache_ram_arbiter.sv
// Single-port arbiter for one icache SRAM bank. After reset (or on request)
// the whole bank is swept with zero writes; otherwise fill writes and lookup
// reads share the port with round-robin priority when both are pending.
module ibex_icache_ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    ibex_icache_ram_arbiter_if.slave bus
);
    localparam int                NUM_LINES = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_LINES - 1);
    localparam logic [DATA_W-1:0] ALL_ONES  = '1;

    typedef enum logic {
        ST_INVAL,
        ST_IDLE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              last_fill;
    logic              rvalid;
    logic              fill_gnt;
    logic              lkp_gnt;

    // Grants and RAM drive; everything is forced to zero while reset is held
    // so the RAM side never sees X or a spurious request.
    always_comb begin
        fill_gnt        = 1'b0;
        lkp_gnt         = 1'b0;
        bus.ram_req_o   = 1'b0;
        bus.ram_write_o = 1'b0;
        bus.ram_addr_o  = '0;
        bus.ram_wdata_o = '0;
        bus.ram_wmask_o = '0;
        if (rst_ni) begin
            if (state == ST_INVAL) begin
                bus.ram_req_o   = 1'b1;
                bus.ram_write_o = 1'b1;
                bus.ram_addr_o  = cnt;
                bus.ram_wmask_o = ALL_ONES;
            end else begin
                // On contention, serve whichever side lost last time.
                fill_gnt = bus.fill_req_i & (~bus.lkp_req_i | ~last_fill);
                lkp_gnt  = bus.lkp_req_i & (~bus.fill_req_i | last_fill);
                if (fill_gnt) begin
                    bus.ram_req_o   = 1'b1;
                    bus.ram_write_o = 1'b1;
                    bus.ram_addr_o  = bus.fill_addr_i;
                    bus.ram_wdata_o = bus.fill_wdata_i;
                    bus.ram_wmask_o = bus.fill_wmask_i;
                end else if (lkp_gnt) begin
                    bus.ram_req_o  = 1'b1;
                    bus.ram_addr_o = bus.lkp_addr_i;
                end
            end
        end
    end

    // Sweep sequencer, round-robin history and read-valid pipeline.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= ST_INVAL;
            cnt       <= '0;
            last_fill <= 1'b0;
            rvalid    <= 1'b0;
        end else begin
            rvalid <= lkp_gnt;
            if (fill_gnt) begin
                last_fill <= 1'b1;
            end else if (lkp_gnt) begin
                last_fill <= 1'b0;
            end
            case (state)
                ST_INVAL: begin
                    if (bus.inval_req_i) begin
                        cnt <= '0;
                    end else if (cnt == LAST_IDX) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (bus.inval_req_i) begin
                        cnt   <= '0;
                        state <= ST_INVAL;
                    end
                end
            endcase
        end
    end

    assign bus.fill_gnt_o   = fill_gnt;
    assign bus.lkp_gnt_o    = lkp_gnt;
    assign bus.lkp_rvalid_o = rvalid & rst_ni;
    assign bus.lkp_rdata_o  = bus.ram_rdata_i;
    assign bus.inval_busy_o = ~rst_ni | (state == ST_INVAL);
endmodule

// File: tb/tb_ibex_icache_ram_arbiter.sv
// Bench for the icache bank arbiter with a 16-line bank and a behavioural RAM.
module tb_ibex_icache_ram_arbiter;
    localparam int AW = 4;
    localparam int DW = 64;
    localparam logic [DW-1:0] FMASK = 64'h00FF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem[2**AW];
    logic [DW-1:0] exp_d;

    ibex_icache_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ibex_icache_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with bit-masked writes and 1-cycle reads.
    always @(posedge clk) begin
        if (bus.ram_req_o) begin
            if (bus.ram_write_o)
                mem[bus.ram_addr_o] <= (mem[bus.ram_addr_o] & ~bus.ram_wmask_o) |
                                       (bus.ram_wdata_o & bus.ram_wmask_o);
            else
                bus.ram_rdata_i <= mem[bus.ram_addr_o];
        end
    end

    // Scoreboard: every rvalid pops the oldest expected read word.
    always @(negedge clk) begin
        if (bus.lkp_rvalid_o === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_rvalid: got rdata %h with nothing expected", bus.lkp_rdata_o);
            end else begin
                exp_d = exp_q.pop_front();
                if (bus.lkp_rdata_o !== exp_d) begin
                    n_err++;
                    $display("FAIL sb_rdata: got %h want %h", bus.lkp_rdata_o, exp_d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        bus.fill_req_i = 1'b1;
        bus.lkp_req_i  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if ({bus.ram_req_o, bus.fill_gnt_o, bus.lkp_gnt_o, bus.lkp_rvalid_o, bus.inval_busy_o} !== 5'b00001) begin
                n_err++;
                $display("FAIL reset_outputs: got req/fg/lg/rv/busy=%b want 00001",
                         {bus.ram_req_o, bus.fill_gnt_o, bus.lkp_gnt_o, bus.lkp_rvalid_o, bus.inval_busy_o});
            end
            tick();
        end
        bus.fill_req_i = 1'b0;
        bus.lkp_req_i  = 1'b0;
        rst_ni = 1'b1;
    endtask

    task automatic test_sweep_then_fill();
        for (int c = 0; c < 16; c++) begin
            if (c >= 3) begin
                bus.fill_req_i   = 1'b1;
                bus.fill_addr_i  = 4'd5;
                bus.fill_wdata_i = 64'hDEAD_BEEF;
                bus.fill_wmask_i = '1;
            end
            #1;
            n_cmp++;
            if (bus.ram_req_o !== 1'b1 || bus.ram_write_o !== 1'b1 || bus.ram_addr_o !== 4'(c) ||
                bus.ram_wdata_o !== '0 || bus.ram_wmask_o !== '1 || bus.inval_busy_o !== 1'b1 ||
                bus.fill_gnt_o !== 1'b0) begin
                n_err++;
                $display("FAIL sweep_cycle c=%0d: got req=%b we=%b addr=%0d wd=%h wm=%h busy=%b fg=%b want 1 1 %0d 0 ones 1 0",
                         c, bus.ram_req_o, bus.ram_write_o, bus.ram_addr_o, bus.ram_wdata_o,
                         bus.ram_wmask_o, bus.inval_busy_o, bus.fill_gnt_o, c);
            end
            tick();
        end
        #1;
        n_cmp++;
        if (bus.inval_busy_o !== 1'b0 || bus.fill_gnt_o !== 1'b1 || bus.ram_write_o !== 1'b1 ||
            bus.ram_addr_o !== 4'd5 || bus.ram_wdata_o !== 64'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL fill_after_sweep: got busy=%b fg=%b we=%b addr=%0d wd=%h want 0 1 1 5 deadbeef",
                     bus.inval_busy_o, bus.fill_gnt_o, bus.ram_write_o, bus.ram_addr_o, bus.ram_wdata_o);
        end
        tick();
        bus.fill_req_i = 1'b0;
        #1;
        n_cmp++;
        if ({bus.ram_req_o, bus.ram_write_o} !== 2'b00 || bus.ram_addr_o !== '0 ||
            bus.ram_wdata_o !== '0 || bus.ram_wmask_o !== '0 || bus.inval_busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle_quiet: got req=%b we=%b addr=%0d wd=%h wm=%h busy=%b want all 0",
                     bus.ram_req_o, bus.ram_write_o, bus.ram_addr_o, bus.ram_wdata_o, bus.ram_wmask_o, bus.inval_busy_o);
        end
    endtask

    task automatic test_lookup();
        bus.lkp_req_i  = 1'b1;
        bus.lkp_addr_i = 4'd5;
        #1;
        n_cmp++;
        if (bus.lkp_gnt_o !== 1'b1 || bus.fill_gnt_o !== 1'b0 || bus.ram_req_o !== 1'b1 ||
            bus.ram_write_o !== 1'b0 || bus.ram_addr_o !== 4'd5 || bus.ram_wdata_o !== '0 ||
            bus.ram_wmask_o !== '0) begin
            n_err++;
            $display("FAIL lookup_grant: got lg=%b fg=%b req=%b we=%b addr=%0d wd=%h wm=%h want 1 0 1 0 5 0 0",
                     bus.lkp_gnt_o, bus.fill_gnt_o, bus.ram_req_o, bus.ram_write_o, bus.ram_addr_o,
                     bus.ram_wdata_o, bus.ram_wmask_o);
        end
        exp_q.push_back(64'hDEAD_BEEF);
        tick();
        bus.lkp_req_i = 1'b0;
        #1;
        n_cmp++;
        if (bus.lkp_rvalid_o !== 1'b1 || bus.lkp_rdata_o !== 64'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL lookup_latency: got rvalid=%b rdata=%h want 1 deadbeef", bus.lkp_rvalid_o, bus.lkp_rdata_o);
        end
        tick();
        n_cmp++;
        if (bus.lkp_rvalid_o !== 1'b0) begin
            n_err++;
            $display("FAIL lookup_rvalid_drop: got %b want 0", bus.lkp_rvalid_o);
        end
    endtask

    task automatic test_arbitration();
        for (int i = 0; i < 6; i++) begin
            bus.fill_req_i   = 1'b1;
            bus.fill_addr_i  = 4'(8 + i);
            bus.fill_wdata_i = {32'hF111_0000, 32'(i)};
            bus.fill_wmask_i = FMASK;
            bus.lkp_req_i    = 1'b1;
            bus.lkp_addr_i   = 4'd5;
            #1;
            n_cmp++;
            if (bus.fill_gnt_o !== ((i % 2) == 0) || bus.lkp_gnt_o !== ((i % 2) == 1) ||
                bus.ram_write_o !== ((i % 2) == 0) ||
                bus.ram_addr_o !== (((i % 2) == 0) ? 4'(8 + i) : 4'd5) ||
                bus.lkp_rvalid_o !== ((i % 2) == 0 && i > 0)) begin
                n_err++;
                $display("FAIL arb_round_robin i=%0d: got fg=%b lg=%b we=%b addr=%0d rv=%b want fg=%b",
                         i, bus.fill_gnt_o, bus.lkp_gnt_o, bus.ram_write_o, bus.ram_addr_o,
                         bus.lkp_rvalid_o, (i % 2) == 0);
            end
            if ((i % 2) == 1) exp_q.push_back(64'hDEAD_BEEF);
            tick();
        end
        bus.fill_req_i = 1'b0;
        bus.lkp_req_i  = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 3; j++) begin
            bus.lkp_req_i  = 1'b1;
            bus.lkp_addr_i = 4'(8 + 2 * j);
            #1;
            n_cmp++;
            if (bus.lkp_gnt_o !== 1'b1 || bus.lkp_rvalid_o !== (j > 0)) begin
                n_err++;
                $display("FAIL b2b_lookup j=%0d: got lg=%b rv=%b want 1 %b", j, bus.lkp_gnt_o, bus.lkp_rvalid_o, j > 0);
            end
            exp_q.push_back({32'hF111_0000, 32'(2 * j)} & FMASK);
            tick();
        end
        bus.lkp_req_i = 1'b0;
        n_cmp++;
        if (bus.lkp_rvalid_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_last_rvalid: got %b want 1", bus.lkp_rvalid_o);
        end
        tick();
    endtask

    task automatic test_inval_restart();
        bus.lkp_req_i   = 1'b1;
        bus.lkp_addr_i  = 4'd5;
        bus.inval_req_i = 1'b1;
        #1;
        n_cmp++;
        if (bus.lkp_gnt_o !== 1'b1 || bus.inval_busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL inval_same_cycle_grant: got lg=%b busy=%b want 1 0", bus.lkp_gnt_o, bus.inval_busy_o);
        end
        exp_q.push_back(64'hDEAD_BEEF);
        tick();
        bus.inval_req_i = 1'b0;
        bus.lkp_req_i   = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 7) bus.inval_req_i = 1'b1;
            #1;
            n_cmp++;
            if (bus.ram_addr_o !== 4'(c) || bus.inval_busy_o !== 1'b1 || bus.ram_write_o !== 1'b1) begin
                n_err++;
                $display("FAIL inval_first_sweep c=%0d: got addr=%0d busy=%b we=%b want %0d 1 1",
                         c, bus.ram_addr_o, bus.inval_busy_o, bus.ram_write_o, c);
            end
            tick();
        end
        bus.inval_req_i  = 1'b0;
        bus.fill_req_i   = 1'b1;
        bus.fill_addr_i  = 4'd3;
        bus.fill_wdata_i = 64'h1234;
        bus.fill_wmask_i = '1;
        for (int c = 0; c < 16; c++) begin
            #1;
            n_cmp++;
            if (bus.ram_addr_o !== 4'(c) || bus.inval_busy_o !== 1'b1 || bus.fill_gnt_o !== 1'b0) begin
                n_err++;
                $display("FAIL inval_restart_sweep c=%0d: got addr=%0d busy=%b fg=%b want %0d 1 0",
                         c, bus.ram_addr_o, bus.inval_busy_o, bus.fill_gnt_o, c);
            end
            tick();
        end
        #1;
        n_cmp++;
        if (bus.inval_busy_o !== 1'b0 || bus.fill_gnt_o !== 1'b1 || bus.ram_addr_o !== 4'd3) begin
            n_err++;
            $display("FAIL inval_fill_after: got busy=%b fg=%b addr=%0d want 0 1 3",
                     bus.inval_busy_o, bus.fill_gnt_o, bus.ram_addr_o);
        end
        tick();
        bus.fill_req_i = 1'b0;
    endtask

    task automatic test_reset_midflight();
        bus.lkp_req_i  = 1'b1;
        bus.lkp_addr_i = 4'd3;
        #1;
        n_cmp++;
        if (bus.lkp_gnt_o !== 1'b1) begin
            n_err++;
            $display("FAIL midflight_grant: got %b want 1", bus.lkp_gnt_o);
        end
        tick();
        bus.lkp_req_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (bus.lkp_rvalid_o !== 1'b0 || bus.ram_req_o !== 1'b0 || bus.inval_busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL midflight_rvalid_dropped: got rv=%b req=%b busy=%b want 0 0 1",
                     bus.lkp_rvalid_o, bus.ram_req_o, bus.inval_busy_o);
        end
        tick();
        rst_ni = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 9) rst_ni = 1'b0;
            #1;
            n_cmp++;
            if (c < 9 && bus.ram_addr_o !== 4'(c)) begin
                n_err++;
                $display("FAIL midsweep_pre c=%0d: got addr=%0d want %0d", c, bus.ram_addr_o, c);
            end else if (c == 9 && {bus.ram_req_o, bus.ram_write_o, bus.lkp_rvalid_o, bus.inval_busy_o} !== 4'b0001) begin
                n_err++;
                $display("FAIL midsweep_reset: got req/we/rv/busy=%b want 0001",
                         {bus.ram_req_o, bus.ram_write_o, bus.lkp_rvalid_o, bus.inval_busy_o});
            end
            tick();
        end
        #1;
        n_cmp++;
        if (bus.ram_req_o !== 1'b0 || bus.ram_addr_o !== '0) begin
            n_err++;
            $display("FAIL midsweep_reset_2nd: got req=%b addr=%0d want 0 0", bus.ram_req_o, bus.ram_addr_o);
        end
        tick();
        rst_ni = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            n_cmp++;
            if (bus.ram_addr_o !== 4'(c) || bus.ram_req_o !== 1'b1 || bus.inval_busy_o !== 1'b1) begin
                n_err++;
                $display("FAIL post_reset_sweep c=%0d: got addr=%0d req=%b busy=%b want %0d 1 1",
                         c, bus.ram_addr_o, bus.ram_req_o, bus.inval_busy_o, c);
            end
            tick();
        end
        #1;
        n_cmp++;
        if (bus.inval_busy_o !== 1'b0 || bus.ram_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: got busy=%b req=%b want 0 0", bus.inval_busy_o, bus.ram_req_o);
        end
    endtask

    initial begin
        bus.inval_req_i  = 1'b0;
        bus.fill_req_i   = 1'b0;
        bus.fill_addr_i  = '0;
        bus.fill_wdata_i = '0;
        bus.fill_wmask_i = '0;
        bus.lkp_req_i    = 1'b0;
        bus.lkp_addr_i   = '0;
        bus.ram_rdata_i  = '0;
        for (int k = 0; k < 2**AW; k++) mem[k] = 64'hBAD0_0000_0000_0000 | 64'(k);

        test_reset();
        test_sweep_then_fill();
        tick();
        test_lookup();
        test_arbitration();
        test_back_to_back();
        test_inval_restart();
        test_reset_midflight();
        tick();
        tick();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d pending reads want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ibex_icache_ram_arbiter.md
# ibex_icache_ram_arbiter

Single-port arbiter and invalidation sequencer for one icache SRAM bank. It sits between the icache core and the RAM wrapper and shares the RAM's one port between three sources: an internal invalidation sweep, line-fill writes, and lookup reads. Its RAM-side outputs drive the interface checked by the icache ECC protocol checker, so they must satisfy the same known-value rules on request cycles.

## Interface
Parameters:
- `ADDR_W`, 8, RAM index width; the bank holds `NUM_LINES = 2**ADDR_W` lines.
- `DATA_W`, 64, RAM data and mask width.

Ports (clock and reset first):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `inval_req_i`  in  1  single-cycle pulse requesting a full-bank invalidation.
- `inval_busy_o`  out  1  high while a sweep is pending or running.
- `fill_req_i`  in  1  fill write request; held until granted.
- `fill_addr_i`  in  ADDR_W  fill index.
- `fill_wdata_i`  in  DATA_W  fill data.
- `fill_wmask_i`  in  DATA_W  fill bit mask.
- `fill_gnt_o`  out  1  fill accepted this cycle.
- `lkp_req_i`  in  1  lookup read request; held until granted.
- `lkp_addr_i`  in  ADDR_W  lookup index.
- `lkp_gnt_o`  out  1  lookup accepted this cycle.
- `lkp_rvalid_o`  out  1  read data valid.
- `lkp_rdata_o`  out  DATA_W  read data, equal to `ram_rdata_i`.
- `ram_req_o`  out  1  RAM access.
- `ram_write_o`  out  1  RAM write enable.
- `ram_addr_o`  out  ADDR_W  RAM index.
- `ram_wdata_o`  out  DATA_W  RAM write data.
- `ram_wmask_o`  out  DATA_W  RAM write mask.
- `ram_rdata_i`  in  DATA_W  RAM read data, one cycle after a read request.

## Operation
- FSM with two states, INVAL and IDLE, plus an `ADDR_W`-bit sweep counter `cnt` and a round-robin bit `last_fill`.
- INVAL:
  - Each cycle: `ram_req_o=1`, `ram_write_o=1`, `ram_addr_o=cnt`, `ram_wdata_o=0`, `ram_wmask_o` all ones.
  - `cnt` increments each cycle.
  - When `cnt==NUM_LINES-1`, the next state is IDLE.
  - `fill_gnt_o` and `lkp_gnt_o` are held at 0.
- IDLE:
  - If only one requester is active, that requester is granted.
  - If `fill_req_i` and `lkp_req_i` are both active, the requester not served last time is granted: fill when `last_fill=0`, lookup when `last_fill=1`.
  - `last_fill` updates on every grant: 1 after a fill grant, 0 after a lookup grant.
  - A fill grant drives the RAM with `write=1` and the fill address, data and mask.
  - A lookup grant drives `write=0`, `addr=lkp_addr_i`, and 0 for wdata and wmask.
- `inval_req_i`:
  - In IDLE: state goes to INVAL with `cnt=0` on the next cycle. Arbitration in the current cycle is unaffected.
  - In INVAL: `cnt` is reloaded to 0 and the sweep restarts.
- When `ram_req_o=0`, `ram_write_o`, `ram_addr_o`, `ram_wdata_o` and `ram_wmask_o` are all driven to 0, so no output is ever X.
- `inval_busy_o = (state==INVAL)`.
- `lkp_rvalid_o` is a register set from `lkp_gnt_o`. `lkp_rdata_o` is a combinational passthrough of `ram_rdata_i`.

## Timing
- Grants are combinational from the requests in the same cycle; a granted request is consumed at that clock edge.
- Read latency: `lkp_rvalid_o` goes high exactly 1 cycle after `lkp_gnt_o`. Back-to-back lookups give back-to-back `rvalid`.
- Sweep duration: `NUM_LINES` cycles. With no restart, the first IDLE cycle is cycle `NUM_LINES` after sweep start, and requests can be granted in that cycle.
- While `rst_ni=0`:
  - `ram_req_o=0`, all grants 0, `lkp_rvalid_o=0`, `inval_busy_o=1`.
  - Registers load `state=INVAL`, `cnt=0`, `last_fill=0`.
- The first cycle after reset release is sweep cycle 0 (addr 0). RAM contents after reset are therefore always invalidated before any lookup is served.
- Reset asserted mid-sweep or mid-lookup: the sweep restarts at 0 and any pending `rvalid` is dropped.
- `cnt` never wraps. The exit from INVAL occurs at `NUM_LINES-1`.

## Test plan
- Reset release, `ADDR_W=4`: 16 consecutive writes to addr 0..15 with wdata 0 and wmask `'1`; `inval_busy_o` falls at cycle 16; `ram_req_o=0` afterwards when idle.
- `fill_req_i` held from sweep cycle 3: `fill_gnt_o` stays 0 until cycle 16, then asserts with `ram_addr_o=fill_addr_i` and `ram_write_o=1`.
- Fill and lookup both held for 6 cycles in IDLE: grants alternate F,L,F,L,F,L (starting with F since `last_fill=0`); no starvation.
- Lookup addr 5 with RAM returning 0xDEAD_BEEF: `lkp_gnt_o` in cycle N with `ram_write_o=0` and addr 5; `lkp_rvalid_o=1` and `lkp_rdata_o=0xDEAD_BEEF` in cycle N+1.
- `inval_req_i` pulsed when `cnt=7`: next write goes to addr 0; busy lasts 16 further cycles; any held fill is granted only afterwards.
- `rst_ni` low for 2 cycles at `cnt=9` with a lookup in flight: `ram_req_o=0` and `lkp_rvalid_o=0` during reset; after release the sweep restarts at addr 0.
